// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch stage with IF/ID register, one-word skid buffer,
// branch redirect and a sticky fault/halt on misaligned or out-of-range fetch.
module fetch_ctrl #(
    parameter int IMEM_BYTES = 84
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        pcsrc,
    input  logic [31:0] branched_PC,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic [31:0] instruction_code,
    output logic        if_valid,
    output logic        fault
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;
    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d, skid_q, skid_d, skid_pc_q, skid_pc_d;
    logic [31:0] pc_q, pc_d, instr_q, instr_d;
    logic        valid_q, valid_d, fault_q, fault_d, req_q, req_d;
    logic [31:0] limit, pc_inc;
    assign limit  = 32'(IMEM_BYTES - 4);
    assign pc_inc = fetch_pc_q + 32'd4;
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        skid_d     = skid_q;
        skid_pc_d  = skid_pc_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        fault_d    = fault_q;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH, HOLD: begin
                if (pcsrc) begin
                    valid_d   = 1'b0;
                    skid_d    = '0;
                    skid_pc_d = '0;
                    if (branched_PC[1:0] != 2'b00) state_d = HALT;
                    else begin
                        fetch_pc_d = branched_PC;
                        state_d    = FETCH;
                    end
                end else if (state_q == FETCH) begin
                    if (imem_ready && stall) begin
                        skid_d     = imem_rdata;
                        skid_pc_d  = fetch_pc_q;
                        fetch_pc_d = pc_inc;
                        state_d    = HOLD;
                    end else if (imem_ready) begin
                        pc_d       = fetch_pc_q;
                        instr_d    = imem_rdata;
                        valid_d    = 1'b1;
                        fetch_pc_d = pc_inc;
                    end else if (!stall) valid_d = 1'b0;
                end else if (!stall) begin
                    pc_d    = skid_pc_q;
                    instr_d = skid_q;
                    valid_d = 1'b1;
                    state_d = FETCH;
                end
            end
            default: state_d = HALT;
        endcase
        // Range check happens before a request can be issued at the new address.
        if (state_d == FETCH && fetch_pc_d > limit) state_d = HALT;
        if (state_d == HALT) begin
            valid_d = 1'b0;
            fault_d = 1'b1;
        end
        req_d = (state_d == FETCH);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= '0;
            skid_q     <= '0;
            skid_pc_q  <= '0;
            pc_q       <= '0;
            instr_q    <= '0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            skid_q     <= skid_d;
            skid_pc_q  <= skid_pc_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
            req_q      <= req_d;
        end
    end
    assign imem_req         = req_q;
    assign imem_addr        = fetch_pc_q;
    assign PC               = pc_q;
    assign instruction_code = instr_q;
    assign if_valid         = valid_q;
    assign fault            = fault_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: table-driven directed vectors for fetch_ctrl plus a hand-written
// skid-then-range-halt sequence.
module tb_fetch_ctrl;
    logic        clk = 1'b0;
    logic        reset, stall, pcsrc, imem_ready;
    logic [31:0] branched_PC, imem_rdata;
    logic        imem_req, if_valid, fault;
    logic [31:0] imem_addr, PC, instruction_code;
    int          checks = 0;
    int          errors = 0;

    fetch_ctrl #(.IMEM_BYTES(84)) dut (
        .clk(clk), .reset(reset), .stall(stall), .pcsrc(pcsrc),
        .branched_PC(branched_PC), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .PC(PC),
        .instruction_code(instruction_code), .if_valid(if_valid), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, stl, br;
        logic [31:0] bpc;
        logic        rdy;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr, pc, ins;
        logic        v, f;
    } vec_t;

    vec_t vecs[28];

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic b, input logic [31:0] bp,
                        input logic rd, input logic [31:0] dat);
        @(negedge clk);
        reset = r; stall = s; pcsrc = b; branched_PC = bp; imem_ready = rd; imem_rdata = dat;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input int row, input logic req, input logic [31:0] addr,
                             input logic [31:0] pc, input logic [31:0] ins, input logic v, input logic f);
        chk("imem_req", row, 32'(imem_req), 32'(req));
        chk("imem_addr", row, imem_addr, addr);
        chk("PC", row, PC, pc);
        chk("instruction_code", row, instruction_code, ins);
        chk("if_valid", row, 32'(if_valid), 32'(v));
        chk("fault", row, 32'(fault), 32'(f));
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; pcsrc = 1'b0; branched_PC = '0; imem_ready = 1'b0; imem_rdata = '0;
        //          rst stl br  bpc    rdy rdata   req addr   pc     ins    v  f
        vecs[0]  = '{1, 0, 0, 32'h0,  0, 32'h0,   0, 32'h0,  32'h0,  32'h0,   0, 0};
        vecs[1]  = '{0, 0, 0, 32'h0,  0, 32'h0,   1, 32'h0,  32'h0,  32'h0,   0, 0};
        vecs[2]  = '{0, 0, 0, 32'h0,  1, 32'h100, 1, 32'h4,  32'h0,  32'h100, 1, 0};
        vecs[3]  = '{0, 0, 0, 32'h0,  1, 32'h104, 1, 32'h8,  32'h4,  32'h104, 1, 0};
        vecs[4]  = '{0, 0, 0, 32'h0,  0, 32'h0,   1, 32'h8,  32'h4,  32'h104, 0, 0};
        vecs[5]  = '{0, 0, 0, 32'h0,  0, 32'h0,   1, 32'h8,  32'h4,  32'h104, 0, 0};
        vecs[6]  = '{0, 0, 0, 32'h0,  1, 32'h108, 1, 32'hC,  32'h8,  32'h108, 1, 0};
        vecs[7]  = '{0, 1, 0, 32'h0,  1, 32'h10C, 0, 32'h10, 32'h8,  32'h108, 1, 0};
        vecs[8]  = '{0, 1, 0, 32'h0,  0, 32'h0,   0, 32'h10, 32'h8,  32'h108, 1, 0};
        vecs[9]  = '{0, 1, 0, 32'h0,  1, 32'hDEAD,0, 32'h10, 32'h8,  32'h108, 1, 0};
        vecs[10] = '{0, 0, 0, 32'h0,  0, 32'h0,   1, 32'h10, 32'hC,  32'h10C, 1, 0};
        vecs[11] = '{0, 1, 1, 32'h20, 1, 32'h110, 1, 32'h20, 32'hC,  32'h10C, 0, 0};
        vecs[12] = '{0, 0, 0, 32'h0,  1, 32'h120, 1, 32'h24, 32'h20, 32'h120, 1, 0};
        vecs[13] = '{0, 0, 1, 32'h22, 0, 32'h0,   0, 32'h24, 32'h20, 32'h120, 0, 1};
        vecs[14] = '{0, 0, 1, 32'h40, 1, 32'h140, 0, 32'h24, 32'h20, 32'h120, 0, 1};
        vecs[15] = '{1, 0, 0, 32'h0,  0, 32'h0,   0, 32'h0,  32'h0,  32'h0,   0, 0};
        vecs[16] = '{0, 0, 0, 32'h0,  0, 32'h0,   1, 32'h0,  32'h0,  32'h0,   0, 0};
        vecs[17] = '{0, 0, 1, 32'h4C, 0, 32'h0,   1, 32'h4C, 32'h0,  32'h0,   0, 0};
        vecs[18] = '{0, 0, 0, 32'h0,  1, 32'h14C, 1, 32'h50, 32'h4C, 32'h14C, 1, 0};
        vecs[19] = '{0, 0, 0, 32'h0,  1, 32'h150, 0, 32'h54, 32'h50, 32'h150, 0, 1};
        vecs[20] = '{1, 0, 0, 32'h0,  0, 32'h0,   0, 32'h0,  32'h0,  32'h0,   0, 0};
        vecs[21] = '{0, 0, 0, 32'h0,  0, 32'h0,   1, 32'h0,  32'h0,  32'h0,   0, 0};
        vecs[22] = '{1, 0, 0, 32'h0,  1, 32'h999, 0, 32'h0,  32'h0,  32'h0,   0, 0};
        vecs[23] = '{0, 0, 0, 32'h0,  0, 32'h0,   1, 32'h0,  32'h0,  32'h0,   0, 0};
        vecs[24] = '{0, 1, 0, 32'h0,  1, 32'h100, 0, 32'h4,  32'h0,  32'h0,   0, 0};
        vecs[25] = '{0, 1, 1, 32'h8,  0, 32'h0,   1, 32'h8,  32'h0,  32'h0,   0, 0};
        vecs[26] = '{0, 0, 0, 32'h0,  1, 32'h108, 1, 32'hC,  32'h8,  32'h108, 1, 0};
        vecs[27] = '{0, 0, 1, 32'h54, 0, 32'h0,   0, 32'h54, 32'h8,  32'h108, 0, 1};
        for (int i = 0; i < 28; i++) begin
            step(vecs[i].rst, vecs[i].stl, vecs[i].br, vecs[i].bpc, vecs[i].rdy, vecs[i].rdata);
            check_all(i, vecs[i].req, vecs[i].addr, vecs[i].pc, vecs[i].ins, vecs[i].v, vecs[i].f);
        end
        // Skid word at the last legal address: it reaches IF/ID, then fetch halts at 0x54.
        step(1, 0, 0, 32'h0, 0, 32'h0);
        check_all(100, 0, 32'h0, 32'h0, 32'h0, 0, 0);
        step(0, 0, 0, 32'h0, 0, 32'h0);
        step(0, 0, 1, 32'h50, 0, 32'h0);
        check_all(101, 1, 32'h50, 32'h0, 32'h0, 0, 0);
        step(0, 1, 0, 32'h0, 1, 32'h150);
        check_all(102, 0, 32'h54, 32'h0, 32'h0, 0, 0);
        step(0, 1, 0, 32'h0, 0, 32'h0);
        check_all(103, 0, 32'h54, 32'h0, 32'h0, 0, 0);
        step(0, 0, 0, 32'h0, 0, 32'h0);
        check_all(104, 0, 32'h54, 32'h50, 32'h150, 0, 1);
        step(0, 0, 1, 32'h0, 1, 32'h0);
        check_all(105, 0, 32'h54, 32'h50, 32'h150, 0, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
